// File: rtl/control_unit_pipe.sv
// Purpose: ID-stage control decoder with the ID/EX and EX/MEM control/PC pipeline registers.
// Latency: id_ctrl is combinational; ex_ctrl/ex_pc lag by 1 edge; mem_ctrl/wb_ctrl/mem_pc lag by 2 edges.
// Backpressure: none. The stages shift every edge, and s=1 injects a zero-control bubble at ID.
//
// Ports:
//   clk, reset (async, active-low)
//   instruction[31:0], s (bubble select), id_pc[31:0]
//   id_ctrl[17:0]  = {ex_ctrl, mem_ctrl, wb_ctrl} decoded in ID
//   ex_ctrl[7:0]   = {alu_op[3:0], reg_dst, ta_mux, rs_addr_mux, jal_adder}, and ex_pc[31:0]
//   mem_ctrl[4:0]  = {load, mem_write, mem_size[1:0], mem_signed}
//   wb_ctrl[4:0]   = {reg_file_enable, hi_enable, lo_enable, write_destination[1:0]}, and mem_pc[31:0]
module control_unit_pipe (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic        s,
  input  logic [31:0] id_pc,
  output logic [17:0] id_ctrl,
  output logic [7:0]  ex_ctrl,
  output logic [31:0] ex_pc,
  output logic [4:0]  mem_ctrl,
  output logic [4:0]  wb_ctrl,
  output logic [31:0] mem_pc
);

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLL  = 4'h6;
  localparam logic [3:0] ALU_SRL  = 4'h7;
  localparam logic [3:0] ALU_SRA  = 4'h8;
  localparam logic [3:0] ALU_SLT  = 4'h9;
  localparam logic [3:0] ALU_SLTU = 4'hA;
  localparam logic [3:0] ALU_LUI  = 4'hB;
  localparam logic [3:0] ALU_PASS = 4'hC;

  logic [5:0] opcode;
  logic [5:0] funct;
  assign opcode = instruction[31:26];
  assign funct  = instruction[5:0];

  logic [3:0] alu_op;
  logic       reg_dst, ta_mux, rs_addr_mux, jal_adder;
  logic       load, mem_write, mem_signed;
  logic [1:0] mem_size;
  logic       rf_en, hi_en, lo_en;
  logic [1:0] wr_dst;
  logic [17:0] dec_ctrl;

  always_comb begin
    alu_op      = ALU_ADD;
    reg_dst     = 1'b0;
    ta_mux      = 1'b0;
    rs_addr_mux = 1'b0;
    jal_adder   = 1'b0;
    load        = 1'b0;
    mem_write   = 1'b0;
    mem_size    = 2'b00;
    mem_signed  = 1'b0;
    rf_en       = 1'b0;
    hi_en       = 1'b0;
    lo_en       = 1'b0;
    wr_dst      = 2'b00;
    unique case (opcode)
      6'h00: begin
        // R-type defaults to rd/rf; the cases below override the exceptions.
        reg_dst = 1'b1;
        rf_en   = 1'b1;
        unique case (funct)
          6'h20, 6'h21: alu_op = ALU_ADD;
          6'h22, 6'h23: alu_op = ALU_SUB;
          6'h24: alu_op = ALU_AND;
          6'h25: alu_op = ALU_OR;
          6'h26: alu_op = ALU_XOR;
          6'h27: alu_op = ALU_NOR;
          6'h2A: alu_op = ALU_SLT;
          6'h2B: alu_op = ALU_SLTU;
          6'h00: begin alu_op = ALU_SLL; rs_addr_mux = 1'b1; end
          6'h02: begin alu_op = ALU_SRL; rs_addr_mux = 1'b1; end
          6'h03: begin alu_op = ALU_SRA; rs_addr_mux = 1'b1; end
          6'h09: jal_adder = 1'b1;
          6'h10: begin alu_op = ALU_PASS; wr_dst = 2'b10; end
          6'h12: begin alu_op = ALU_PASS; wr_dst = 2'b11; end
          6'h11: begin alu_op = ALU_PASS; hi_en = 1'b1; rf_en = 1'b0; reg_dst = 1'b0; end
          6'h13: begin alu_op = ALU_PASS; lo_en = 1'b1; rf_en = 1'b0; reg_dst = 1'b0; end
          // jr and unrecognised functs decode to an all-zero word.
          default: begin reg_dst = 1'b0; rf_en = 1'b0; end
        endcase
      end
      6'h08, 6'h09: begin ta_mux = 1'b1; rf_en = 1'b1; alu_op = ALU_ADD;  end
      6'h0A:        begin ta_mux = 1'b1; rf_en = 1'b1; alu_op = ALU_SLT;  end
      6'h0B:        begin ta_mux = 1'b1; rf_en = 1'b1; alu_op = ALU_SLTU; end
      6'h0C:        begin ta_mux = 1'b1; rf_en = 1'b1; alu_op = ALU_AND;  end
      6'h0D:        begin ta_mux = 1'b1; rf_en = 1'b1; alu_op = ALU_OR;   end
      6'h0E:        begin ta_mux = 1'b1; rf_en = 1'b1; alu_op = ALU_XOR;  end
      6'h0F:        begin ta_mux = 1'b1; rf_en = 1'b1; alu_op = ALU_LUI;  end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        ta_mux = 1'b1; load = 1'b1; rf_en = 1'b1; wr_dst = 2'b01;
        mem_size   = (opcode == 6'h23) ? 2'b10 :
                     (opcode == 6'h21 || opcode == 6'h25) ? 2'b01 : 2'b00;
        mem_signed = (opcode == 6'h20 || opcode == 6'h21);
      end
      6'h28, 6'h29, 6'h2B: begin
        ta_mux = 1'b1; mem_write = 1'b1;
        mem_size = (opcode == 6'h2B) ? 2'b10 : (opcode == 6'h29) ? 2'b01 : 2'b00;
      end
      6'h04, 6'h05: alu_op = ALU_SUB;
      6'h03: begin jal_adder = 1'b1; rf_en = 1'b1; end
      default: ; // j and unrecognised opcodes: all zero
    endcase
  end

  assign dec_ctrl = {alu_op, reg_dst, ta_mux, rs_addr_mux, jal_adder,
                     load, mem_write, mem_size, mem_signed,
                     rf_en, hi_en, lo_en, wr_dst};

  // Bubble mux; a zero instruction (nop) and reset also produce a zero word.
  assign id_ctrl = (s || !reset || instruction == 32'h0) ? 18'h0 : dec_ctrl;

  // ID/EX stage holds all three groups; the EX group is dropped at EX/MEM.
  logic [4:0] ex_mem_q;
  logic [4:0] ex_wb_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_ctrl  <= 8'h0;
      ex_mem_q <= 5'h0;
      ex_wb_q  <= 5'h0;
      ex_pc    <= 32'h0;
      mem_ctrl <= 5'h0;
      wb_ctrl  <= 5'h0;
      mem_pc   <= 32'h0;
    end else begin
      ex_ctrl  <= id_ctrl[17:10];
      ex_mem_q <= id_ctrl[9:5];
      ex_wb_q  <= id_ctrl[4:0];
      ex_pc    <= id_pc;
      mem_ctrl <= ex_mem_q;
      wb_ctrl  <= ex_wb_q;
      mem_pc   <= ex_pc;
    end
  end

endmodule

// File: tb/tb_control_unit_pipe.sv
module tb_control_unit_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic        s;
  logic [31:0] id_pc;
  logic [17:0] id_ctrl;
  logic [7:0]  ex_ctrl;
  logic [31:0] ex_pc;
  logic [4:0]  mem_ctrl;
  logic [4:0]  wb_ctrl;
  logic [31:0] mem_pc;

  int n_assert = 0;
  int n_fail   = 0;

  control_unit_pipe dut (
    .clk(clk), .reset(reset), .instruction(instruction), .s(s), .id_pc(id_pc),
    .id_ctrl(id_ctrl), .ex_ctrl(ex_ctrl), .ex_pc(ex_pc),
    .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl), .mem_pc(mem_pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input string tag, input logic [31:0] ins, input logic [17:0] exp);
    instruction = ins;
    #1;
    check(tag, {14'h0, id_ctrl}, {14'h0, exp});
  endtask

  initial begin
    reset = 1'b0; s = 1'b0; instruction = 32'h2001_0005; id_pc = 32'h100;
    step(); step(); step();
    check("rst_id_ctrl",  {14'h0, id_ctrl}, 32'h0);
    check("rst_ex_ctrl",  {24'h0, ex_ctrl}, 32'h0);
    check("rst_ex_pc",    ex_pc, 32'h0);
    check("rst_mem_ctrl", {27'h0, mem_ctrl}, 32'h0);
    check("rst_wb_ctrl",  {27'h0, wb_ctrl}, 32'h0);
    check("rst_mem_pc",   mem_pc, 32'h0);

    reset = 1'b1;
    #1;
    check("addi_id_ctrl", {14'h0, id_ctrl}, {14'h0, 8'b00000100, 5'b00000, 5'b10000});
    step();
    check("addi_ex_ctrl", {24'h0, ex_ctrl}, {24'h0, 8'b00000100});
    check("addi_ex_pc",   ex_pc, 32'h100);
    instruction = 32'h0; id_pc = 32'h104;
    step();
    check("nop_ex_ctrl",   {24'h0, ex_ctrl}, 32'h0);
    check("addi_mem_ctrl", {27'h0, mem_ctrl}, {27'h0, 5'b00000});
    check("addi_wb_ctrl",  {27'h0, wb_ctrl}, {27'h0, 5'b10000});
    check("addi_mem_pc",   mem_pc, 32'h100);

    instruction = 32'h8C22_0004; id_pc = 32'h108;
    step();
    check("lw_ex_ctrl", {24'h0, ex_ctrl}, {24'h0, 8'b00000100});
    instruction = 32'hAC22_0004; id_pc = 32'h10C;
    step();
    check("lw_mem_ctrl", {27'h0, mem_ctrl}, {27'h0, 5'b10100});
    check("lw_wb_ctrl",  {27'h0, wb_ctrl}, {27'h0, 5'b10001});
    check("lw_mem_pc",   mem_pc, 32'h108);
    check("sw_ex_ctrl",  {24'h0, ex_ctrl}, {24'h0, 8'b00000100});
    instruction = 32'h0022_1820; id_pc = 32'h110;
    step();
    check("sw_mem_ctrl", {27'h0, mem_ctrl}, {27'h0, 5'b01100});
    check("sw_wb_ctrl",  {27'h0, wb_ctrl}, {27'h0, 5'b00000});
    check("add_ex_ctrl", {24'h0, ex_ctrl}, {24'h0, 8'b00001000});
    s = 1'b1; id_pc = 32'h114;
    #1;
    check("bubble_id_ctrl", {14'h0, id_ctrl}, 32'h0);
    step();
    check("bubble_ex_ctrl", {24'h0, ex_ctrl}, 32'h0);
    check("add_wb_ctrl",    {27'h0, wb_ctrl}, {27'h0, 5'b10000});
    check("add_mem_ctrl",   {27'h0, mem_ctrl}, 32'h0);
    s = 1'b0; instruction = 32'h0C00_0010; id_pc = 32'h118;
    step();
    check("jal_ex_ctrl",    {24'h0, ex_ctrl}, {24'h0, 8'b00000001});
    check("bubble_wb_ctrl", {27'h0, wb_ctrl}, 32'h0);
    instruction = 32'h0;
    step();
    check("jal_wb_ctrl", {27'h0, wb_ctrl}, {27'h0, 5'b10000});
    check("jal_mem_pc",  mem_pc, 32'h118);

    // Combinational decode table: {ex 8, mem 5, wb 5}
    dec("sll",   32'h0002_1080, {8'b01101010, 5'b00000, 5'b10000});
    dec("sra",   32'h0002_1083, {8'b10001010, 5'b00000, 5'b10000});
    dec("nor",   32'h0022_1827, {8'b01011000, 5'b00000, 5'b10000});
    dec("sltu",  32'h0022_182B, {8'b10101000, 5'b00000, 5'b10000});
    dec("jalr",  32'h0040_F809, {8'b00001001, 5'b00000, 5'b10000});
    dec("mfhi",  32'h0000_1810, {8'b11001000, 5'b00000, 5'b10010});
    dec("mflo",  32'h0000_1812, {8'b11001000, 5'b00000, 5'b10011});
    dec("mthi",  32'h0020_0011, {8'b11000000, 5'b00000, 5'b01000});
    dec("mtlo",  32'h0020_0013, {8'b11000000, 5'b00000, 5'b00100});
    dec("jr",    32'h03E0_0008, 18'h0);
    dec("bad_funct", 32'h0022_1801, 18'h0);
    dec("lui",   32'h3C01_1234, {8'b10110100, 5'b00000, 5'b10000});
    dec("sltiu", 32'h2C22_0005, {8'b10100100, 5'b00000, 5'b10000});
    dec("ori",   32'h3422_0005, {8'b00110100, 5'b00000, 5'b10000});
    dec("lh",    32'h8422_0002, {8'b00000100, 5'b10011, 5'b10001});
    dec("lbu",   32'h9022_0000, {8'b00000100, 5'b10000, 5'b10001});
    dec("lb",    32'h8022_0000, {8'b00000100, 5'b10001, 5'b10001});
    dec("sh",    32'hA422_0000, {8'b00000100, 5'b01010, 5'b00000});
    dec("sb",    32'hA022_0000, {8'b00000100, 5'b01000, 5'b00000});
    dec("beq",   32'h1022_0003, {8'b00010000, 5'b00000, 5'b00000});
    dec("bne",   32'h1422_0003, {8'b00010000, 5'b00000, 5'b00000});
    dec("j",     32'h0800_0010, 18'h0);
    dec("bad_op", 32'hFC00_0000, 18'h0);

    // Reset asserted between edges while lw sits in EX/MEM.
    instruction = 32'h8C22_0004; id_pc = 32'h200;
    step();
    instruction = 32'h0; id_pc = 32'h204;
    step();
    check("mid_lw_mem_ctrl", {27'h0, mem_ctrl}, {27'h0, 5'b10100});
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_mem_ctrl", {27'h0, mem_ctrl}, 32'h0);
    check("mid_rst_wb_ctrl",  {27'h0, wb_ctrl}, 32'h0);
    check("mid_rst_mem_pc",   mem_pc, 32'h0);
    check("mid_rst_ex_pc",    ex_pc, 32'h0);
    step();
    reset = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
